// File: rtl/bd_word_source.sv
// BD chip input-side port emulator: seeded pseudo-random words over an active-low-valid /
// active-high-ready handshake, separated by seeded pseudo-random idle gaps.
module bd_word_source #(
  parameter int          NUM_BITS   = 34,
  parameter int          DelayMin   = 0,
  parameter int          DelayMax   = 200,
  parameter logic [63:0] DATA_SEED  = 64'hACE1_2468_BDF0_1357,
  parameter logic [15:0] DELAY_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_BITS-1:0] data,
  output logic                valid_n,
  input  logic                ready,
  output logic [31:0]         sent_count
);

  // state      | meaning
  // ST_LOAD    | reset value; first edge after release draws d_0
  // ST_WAIT    | idle gap; gap_cnt_q counts down to zero
  // ST_PRESENT | word on data with valid_n low, held until ready
  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_PRESENT} state_e;

  // 17 bits: the gap span can be a full 65536 when DelayMin = 0 and DelayMax = 65535
  localparam logic [16:0] GapSpan = 17'(DelayMax - DelayMin + 1);
  localparam logic [15:0] GapBase = 16'(DelayMin);

  state_e      state_q;
  logic [63:0] data_lfsr_q;
  logic [63:0] data_lfsr_d;
  logic [15:0] delay_lfsr_q;
  logic [15:0] delay_lfsr_d;
  logic [15:0] gap_cnt_q;
  logic [15:0] gap;

  always_comb begin
    data_lfsr_d  = {data_lfsr_q[62:0],
                    data_lfsr_q[63] ^ data_lfsr_q[62] ^ data_lfsr_q[60] ^ data_lfsr_q[59]};
    delay_lfsr_d = {delay_lfsr_q[14:0],
                    delay_lfsr_q[15] ^ delay_lfsr_q[14] ^ delay_lfsr_q[12] ^ delay_lfsr_q[3]};
    gap          = GapBase + 16'({1'b0, delay_lfsr_q} % GapSpan);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      data_lfsr_q  <= DATA_SEED;
      delay_lfsr_q <= DELAY_SEED;
      gap_cnt_q    <= '0;
      data         <= '0;
      valid_n      <= 1'b1;
      sent_count   <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          delay_lfsr_q <= delay_lfsr_d;
          if (gap == 16'd0) begin
            data    <= data_lfsr_q[NUM_BITS-1:0];
            valid_n <= 1'b0;
            state_q <= ST_PRESENT;
          end else begin
            gap_cnt_q <= gap - 16'd1;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (gap_cnt_q == 16'd0) begin
            data    <= data_lfsr_q[NUM_BITS-1:0];
            valid_n <= 1'b0;
            state_q <= ST_PRESENT;
          end else begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end
        end
        ST_PRESENT: begin
          if (ready) begin
            sent_count   <= sent_count + 32'd1;
            data_lfsr_q  <= data_lfsr_d;
            delay_lfsr_q <= delay_lfsr_d;
            // zero gap: the next word goes out on this same edge, no bubble
            if (gap == 16'd0) begin
              data <= data_lfsr_d[NUM_BITS-1:0];
            end else begin
              valid_n   <= 1'b1;
              gap_cnt_q <= gap - 16'd1;
              state_q   <= ST_WAIT;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bd_word_source.sv
// Self-checking bench for bd_word_source: three instances (default gaps, zero gaps, 3..10 gaps)
// compared against a transaction-level model of the word and gap sequences.
module tb_bd_word_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  rdy;
  logic [2:0]  vn;
  logic [33:0] dat [3];
  logic [31:0] cnt [3];

  int errors = 0;
  int checks = 0;
  bit stuck  = 1'b0;

  int dmin [3] = '{0, 0, 3};
  int dmax [3] = '{200, 0, 10};

  logic        prev_v [3];
  int          run    [3];
  logic [31:0] acc    [3];
  logic [15:0] mq     [3];
  logic [63:0] ms     [3];

  bd_word_source u_def (
    .clk(clk), .reset(rst_n[0]), .data(dat[0]), .valid_n(vn[0]), .ready(rdy[0]), .sent_count(cnt[0])
  );
  bd_word_source #(.DelayMin(0), .DelayMax(0)) u_zero (
    .clk(clk), .reset(rst_n[1]), .data(dat[1]), .valid_n(vn[1]), .ready(rdy[1]), .sent_count(cnt[1])
  );
  bd_word_source #(.DelayMin(3), .DelayMax(10)) u_rng (
    .clk(clk), .reset(rst_n[2]), .data(dat[2]), .valid_n(vn[2]), .ready(rdy[2]), .sent_count(cnt[2])
  );

  function automatic logic [63:0] dnext(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  function automatic logic [15:0] qnext(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[14] ^ q[12] ^ q[3]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    prev_v[i] = 1'b1;
    run[i]    = 0;
    acc[i]    = '0;
    mq[i]     = 16'hACE1;
    ms[i]     = 64'hACE1_2468_BDF0_1357;
  endtask

  // One cycle: observe after the edge, update model, choose ready for the next edge.
  // mode 0: ready low, 1: ready high, 2: random, 3: ready high only while valid_n is high
  task automatic step(input int i, input int mode);
    bit accepted;
    bit fresh;
    int gap;
    @(negedge clk);
    accepted = !prev_v[i] && rdy[i];
    if (accepted) begin
      acc[i]++;
      ms[i] = dnext(ms[i]);
    end
    fresh = !vn[i] && (prev_v[i] || accepted);
    if (fresh) begin
      gap = dmin[i] + (int'(mq[i]) % (dmax[i] - dmin[i] + 1));
      check("gap", 64'(run[i]), 64'(gap));
      mq[i]  = qnext(mq[i]);
      run[i] = 0;
    end
    if (!vn[i]) begin
      check("data", 64'(dat[i]), 64'(ms[i][33:0]));
    end else begin
      run[i]++;
      if (run[i] > dmax[i] + 1) begin
        check("gap_timeout", 64'(run[i]), 64'(dmax[i]));
        stuck = 1'b1;
      end
    end
    check("count", 64'(cnt[i]), 64'(acc[i]));
    prev_v[i] = vn[i];
    case (mode)
      0:       rdy[i] = 1'b0;
      1:       rdy[i] = 1'b1;
      3:       rdy[i] = vn[i];
      default: rdy[i] = ($urandom_range(7, 0) != 0);
    endcase
  endtask

  task automatic run_words(input int i, input int n, input int mode);
    int budget = 60000;
    while (acc[i] < 32'(n) && !stuck && budget > 0) begin
      step(i, mode);
      budget--;
    end
    if (budget == 0) check("word_budget", 64'(acc[i]), 64'(n));
  endtask

  task automatic first_word(input int i, input string tag);
    int edges = 0;
    do begin
      step(i, 1);
      edges++;
    end while (vn[i] && !stuck);
    check({tag, "_edge"}, 64'(edges), 64'd38);
    check({tag, "_data"}, 64'(dat[i]), 64'h0BDF01357);
  endtask

  initial begin
    rst_n = 3'b000;
    rdy   = 3'b111;
    for (int i = 0; i < 3; i++) model_reset(i);
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(vn[0]), 64'd1);
    check("rst_data", 64'(dat[0]), 64'd0);
    check("rst_count", 64'(cnt[0]), 64'd0);

    // first word and first acceptance
    rst_n[0] = 1'b1;
    first_word(0, "first");
    step(0, 1);
    check("first_count", 64'(cnt[0]), 64'd1);

    // ready high through the gap is ignored, then 500 cycles of backpressure
    do step(0, 3); while (vn[0] && !stuck);
    repeat (500) step(0, 0);
    check("bp_valid", 64'(vn[0]), 64'd0);
    check("bp_count", 64'(cnt[0]), 64'd1);
    step(0, 1);
    step(0, 0);
    repeat (20) step(0, 0);
    check("one_xfer", 64'(cnt[0]), 64'd2);

    run_words(0, 32, 2);

    // reset while a word is pending
    do step(0, 3); while (vn[0] && !stuck);
    #2 rst_n[0] = 1'b0;
    #1;
    check("async_valid", 64'(vn[0]), 64'd1);
    check("async_count", 64'(cnt[0]), 64'd0);
    model_reset(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    first_word(0, "restart");
    rst_n[0] = 1'b0;

    // zero-gap streaming
    rst_n[1] = 1'b1;
    repeat (101) step(1, 1);
    check("stream_count", 64'(cnt[1]), 64'd100);
    check("stream_valid", 64'(vn[1]), 64'd0);
    rst_n[1] = 1'b0;

    // bounded gaps with random ready
    rst_n[2] = 1'b1;
    run_words(2, 5000, 2);
    check("range_words", 64'(acc[2]), 64'd5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
